// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
//
// Purpose: holds dispatched operations until both source operands are
// available, wakes operands from the broadcast (CDB) ports, and offers one
// ready entry per cycle to a functional unit.
//
// Compile-time option: RS_AGE_ORDER_EN
//   defined   -> a DEPTH x DEPTH age matrix selects the oldest ready entry
//   undefined -> the lowest-index ready entry is selected, no age storage
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   flush                  drop every entry at the edge
//   dispatch_*             incoming operation (tags, operand-valid bits,
//                          destination, ROB index, opaque payload)
//   cdb_valid / cdb_preg   NUM_CDB wakeup ports, port k tag at
//                          cdb_preg[k*PREG_W +: PREG_W]
//   issue_*                selected ready entry towards the functional unit
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. dispatch_ready depends only on registered occupancy; issue_valid
// may drop while stalled (flush) and the issue payload may change while
// issue_ready=0 -- the consumer only samples it on the handshake edge.
// ---------------------------------------------------------------------------
module reservation_station #(
    parameter int DEPTH   = 8,
    parameter int PREG_W  = 6,
    parameter int ROB_W   = 5,
    parameter int NUM_CDB = 2,
    parameter int CTRL_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      dispatch_valid,
    output logic                      dispatch_ready,
    input  logic [PREG_W-1:0]         dispatch_ps1,
    input  logic                      dispatch_ps1_v,
    input  logic [PREG_W-1:0]         dispatch_ps2,
    input  logic                      dispatch_ps2_v,
    input  logic [PREG_W-1:0]         dispatch_pd,
    input  logic [ROB_W-1:0]          dispatch_rob,
    input  logic [CTRL_W-1:0]         dispatch_ctrl,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*PREG_W-1:0] cdb_preg,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [PREG_W-1:0]         issue_ps1,
    output logic [PREG_W-1:0]         issue_ps2,
    output logic [PREG_W-1:0]         issue_pd,
    output logic [ROB_W-1:0]          issue_rob,
    output logic [CTRL_W-1:0]         issue_ctrl
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_ps1_v;
    logic [DEPTH-1:0]  r_ps2_v;
    logic [PREG_W-1:0] r_ps1  [DEPTH];
    logic [PREG_W-1:0] r_ps2  [DEPTH];
    logic [PREG_W-1:0] r_pd   [DEPTH];
    logic [ROB_W-1:0]  r_rob  [DEPTH];
    logic [CTRL_W-1:0] r_ctrl [DEPTH];

    logic [DEPTH-1:0]  w_ready;
    logic [DEPTH-1:0]  w_wake1;
    logic [DEPTH-1:0]  w_wake2;
    logic              w_disp_hit1;
    logic              w_disp_hit2;
    logic [IDX_W-1:0]  w_free_idx;
    logic [IDX_W-1:0]  w_sel;
    logic              w_do_dispatch;
    logic              w_do_issue;

    // True when any valid broadcast port carries this tag.
    function automatic logic cdb_hit(input logic [PREG_W-1:0] tag,
                                     input logic [NUM_CDB-1:0] vld,
                                     input logic [NUM_CDB*PREG_W-1:0] tags);
        cdb_hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (vld[k] && (tags[k*PREG_W +: PREG_W] == tag)) begin
                cdb_hit = 1'b1;
            end
        end
    endfunction

    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wake1[i] = cdb_hit(r_ps1[i], cdb_valid, cdb_preg);
            w_wake2[i] = cdb_hit(r_ps2[i], cdb_valid, cdb_preg);
        end
        w_disp_hit1 = cdb_hit(dispatch_ps1, cdb_valid, cdb_preg);
        w_disp_hit2 = cdb_hit(dispatch_ps2, cdb_valid, cdb_preg);
    end

    assign w_ready = r_busy & r_ps1_v & r_ps2_v;

    // Lowest-index free entry: scan downwards so the lowest match wins.
    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

`ifdef RS_AGE_ORDER_EN
    // r_age[i][j] = 1 means entry i was dispatched before entry j.
    logic [DEPTH-1:0] r_age [DEPTH];
    logic [DEPTH-1:0] w_is_oldest;

    always_comb begin
        w_is_oldest = w_ready;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && w_ready[j] && r_age[j][i]) begin
                    w_is_oldest[i] = 1'b0;
                end
            end
        end
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_is_oldest[i]) begin
                w_sel = IDX_W'(i);
            end
        end
    end
`else
    always_comb begin
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel = IDX_W'(i);
            end
        end
    end
`endif

    assign dispatch_ready = ~&r_busy;
    assign issue_valid    = (|w_ready) && !flush;
    assign w_do_dispatch  = dispatch_valid && dispatch_ready;
    assign w_do_issue     = issue_valid && issue_ready;

    assign issue_ps1  = issue_valid ? r_ps1[w_sel]  : '0;
    assign issue_ps2  = issue_valid ? r_ps2[w_sel]  : '0;
    assign issue_pd   = issue_valid ? r_pd[w_sel]   : '0;
    assign issue_rob  = issue_valid ? r_rob[w_sel]  : '0;
    assign issue_ctrl = issue_valid ? r_ctrl[w_sel] : '0;

    // The dispatch target is always a free entry and the issue target is
    // always busy, so the two writes never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_ps1_v <= '0;
            r_ps2_v <= '0;
`ifdef RS_AGE_ORDER_EN
            for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
`endif
        end else if (flush) begin
            r_busy <= '0;
`ifdef RS_AGE_ORDER_EN
            for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
`endif
        end else begin
            r_ps1_v <= r_ps1_v | (r_busy & w_wake1);
            r_ps2_v <= r_ps2_v | (r_busy & w_wake2);
            if (w_do_issue) begin
                r_busy[w_sel] <= 1'b0;
            end
            if (w_do_dispatch) begin
                r_busy[w_free_idx]  <= 1'b1;
                r_ps1_v[w_free_idx] <= dispatch_ps1_v | w_disp_hit1;
                r_ps2_v[w_free_idx] <= dispatch_ps2_v | w_disp_hit2;
                r_ps1[w_free_idx]   <= dispatch_ps1;
                r_ps2[w_free_idx]   <= dispatch_ps2;
                r_pd[w_free_idx]    <= dispatch_pd;
                r_rob[w_free_idx]   <= dispatch_rob;
                r_ctrl[w_free_idx]  <= dispatch_ctrl;
`ifdef RS_AGE_ORDER_EN
                // New entry is younger than every other entry.
                r_age[w_free_idx] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (IDX_W'(j) != w_free_idx) begin
                        r_age[j][w_free_idx] <= 1'b1;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_reservation_station
//
// Directed bench for reservation_station. Inputs change just after the
// falling edge; outputs are checked 1 time unit later, well away from the
// rising edge that commits state.
// ---------------------------------------------------------------------------
module tb_reservation_station;

    localparam int DEPTH   = 8;
    localparam int PREG_W  = 6;
    localparam int ROB_W   = 5;
    localparam int NUM_CDB = 2;
    localparam int CTRL_W  = 32;

    logic                      clk;
    logic                      rst;
    logic                      flush;
    logic                      dispatch_valid;
    logic                      dispatch_ready;
    logic [PREG_W-1:0]         dispatch_ps1;
    logic                      dispatch_ps1_v;
    logic [PREG_W-1:0]         dispatch_ps2;
    logic                      dispatch_ps2_v;
    logic [PREG_W-1:0]         dispatch_pd;
    logic [ROB_W-1:0]          dispatch_rob;
    logic [CTRL_W-1:0]         dispatch_ctrl;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*PREG_W-1:0] cdb_preg;
    logic                      issue_valid;
    logic                      issue_ready;
    logic [PREG_W-1:0]         issue_ps1;
    logic [PREG_W-1:0]         issue_ps2;
    logic [PREG_W-1:0]         issue_pd;
    logic [ROB_W-1:0]          issue_rob;
    logic [CTRL_W-1:0]         issue_ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_rob;

    reservation_station #(
        .DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W),
        .NUM_CDB(NUM_CDB), .CTRL_W(CTRL_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_ps1(dispatch_ps1), .dispatch_ps1_v(dispatch_ps1_v),
        .dispatch_ps2(dispatch_ps2), .dispatch_ps2_v(dispatch_ps2_v),
        .dispatch_pd(dispatch_pd), .dispatch_rob(dispatch_rob),
        .dispatch_ctrl(dispatch_ctrl),
        .cdb_valid(cdb_valid), .cdb_preg(cdb_preg),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_ps1(issue_ps1), .issue_ps2(issue_ps2), .issue_pd(issue_pd),
        .issue_rob(issue_rob), .issue_ctrl(issue_ctrl)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- driver tasks ----
    task automatic set_idle();
        flush          = 1'b0;
        dispatch_valid = 1'b0;
        dispatch_ps1   = '0;
        dispatch_ps1_v = 1'b0;
        dispatch_ps2   = '0;
        dispatch_ps2_v = 1'b0;
        dispatch_pd    = '0;
        dispatch_rob   = '0;
        dispatch_ctrl  = '0;
        cdb_valid      = '0;
        cdb_preg       = '0;
        issue_ready    = 1'b0;
    endtask

    task automatic drive_dispatch(input int ps1, input int v1, input int ps2,
                                  input int v2, input int pd, input int rob,
                                  input int ctrl);
        dispatch_valid = 1'b1;
        dispatch_ps1   = PREG_W'(ps1);
        dispatch_ps1_v = v1[0];
        dispatch_ps2   = PREG_W'(ps2);
        dispatch_ps2_v = v2[0];
        dispatch_pd    = PREG_W'(pd);
        dispatch_rob   = ROB_W'(rob);
        dispatch_ctrl  = CTRL_W'(ctrl);
    endtask

    // Advance to the next falling edge, return inputs to idle, settle.
    task automatic next_step();
        @(negedge clk);
        set_idle();
        #1;
    endtask

    // ---- scoreboard compare ----
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_dispatch_ready", 32'(dispatch_ready), 1);
        check("rst_issue_valid",    32'(issue_valid), 0);
        check("rst_issue_ps1",      32'(issue_ps1), 0);
        check("rst_issue_rob",      32'(issue_rob), 0);
        check("rst_issue_ctrl",     issue_ctrl, 0);

        // CDB wakeup: ps1=5 pending, ps2=6 available
        drive_dispatch(5, 0, 6, 1, 10, 4, 32'hA5A5_0001);
        next_step();
        cdb_valid = 2'b01;
        cdb_preg  = {6'd0, 6'd5};
        #1;
        check("wake_before_edge_valid", 32'(issue_valid), 0);
        next_step();
        check("wake_issue_valid", 32'(issue_valid), 1);
        check("wake_issue_ps1",   32'(issue_ps1), 5);
        check("wake_issue_ps2",   32'(issue_ps2), 6);
        check("wake_issue_pd",    32'(issue_pd), 10);
        check("wake_issue_rob",   32'(issue_rob), 4);
        check("wake_issue_ctrl",  issue_ctrl, 32'hA5A5_0001);
        issue_ready = 1'b1;
        next_step();
        check("wake_after_issue_valid", 32'(issue_valid), 0);

        // Dispatch bypass from CDB port 1
        drive_dispatch(9, 0, 3, 1, 11, 7, 32'h0000_0009);
        cdb_valid = 2'b10;
        cdb_preg  = {6'd9, 6'd0};
        #1;
        check("bypass_same_cycle_valid", 32'(issue_valid), 0);
        next_step();
        check("bypass_issue_valid", 32'(issue_valid), 1);
        check("bypass_issue_ps1",   32'(issue_ps1), 9);
        check("bypass_issue_rob",   32'(issue_rob), 7);
        issue_ready = 1'b1;
        next_step();

        // Non-matching tag must not wake; then both ports carry the tag
        drive_dispatch(7, 0, 2, 1, 12, 8, 0);
        cdb_valid = 2'b01;
        cdb_preg  = {6'd0, 6'd8};
        next_step();
        check("nomatch_issue_valid", 32'(issue_valid), 0);
        cdb_valid = 2'b11;
        cdb_preg  = {6'd7, 6'd7};
        next_step();
        check("dualport_issue_valid", 32'(issue_valid), 1);
        check("dualport_issue_rob",   32'(issue_rob), 8);
        issue_ready = 1'b1;
        next_step();
        check("dualport_drained", 32'(issue_valid), 0);

        // Fill all entries with ready ops, issue stalled
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_dispatch_ready", 32'(dispatch_ready), 1);
            drive_dispatch(1, 1, 2, 1, 20 + i, i, 100 + i);
            exp_q.push_back(32'(i));
            next_step();
        end
        check("full_dispatch_ready", 32'(dispatch_ready), 0);
        drive_dispatch(1, 1, 2, 1, 30, 31, 999);
        next_step();
        check("full_ninth_ignored_ready", 32'(dispatch_ready), 0);
        check("full_issue_valid", 32'(issue_valid), 1);
        issue_ready = 1'b1;
        #1;
        check("full_ready_during_issue", 32'(dispatch_ready), 0);
        exp_rob = exp_q.pop_front();
        check("full_first_issue_rob", 32'(issue_rob), exp_rob);
        next_step();
        check("full_ready_after_issue", 32'(dispatch_ready), 1);
        while (exp_q.size() > 0) begin
            exp_rob = exp_q.pop_front();
            check("drain_issue_valid", 32'(issue_valid), 1);
            check("drain_issue_rob",   32'(issue_rob), exp_rob);
            issue_ready = 1'b1;
            next_step();
        end
        check("drain_empty", 32'(issue_valid), 0);

        // Selection policy: entry 0 reused by a younger op
        drive_dispatch(1, 1, 2, 1, 40, 1, 0);
        next_step();
        drive_dispatch(1, 1, 2, 1, 41, 2, 0);
        issue_ready = 1'b1;
        #1;
        check("order_first_rob", 32'(issue_rob), 1);
        next_step();
        drive_dispatch(1, 1, 2, 1, 42, 3, 0);
        next_step();
`ifdef RS_AGE_ORDER_EN
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd3);
`else
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd2);
`endif
        while (exp_q.size() > 0) begin
            exp_rob = exp_q.pop_front();
            check("order_issue_rob", 32'(issue_rob), exp_rob);
            issue_ready = 1'b1;
            next_step();
        end
        check("order_empty", 32'(issue_valid), 0);

        // Flush with 4 busy entries and a concurrent dispatch/issue
        for (int i = 0; i < 4; i++) begin
            drive_dispatch(1, 1, 2, 1, 50 + i, 10 + i, 0);
            next_step();
        end
        check("preflush_issue_valid", 32'(issue_valid), 1);
        flush       = 1'b1;
        issue_ready = 1'b1;
        drive_dispatch(1, 1, 2, 1, 60, 20, 0);
        #1;
        check("flush_issue_valid", 32'(issue_valid), 0);
        check("flush_issue_rob",   32'(issue_rob), 0);
        next_step();
        check("postflush_issue_valid",    32'(issue_valid), 0);
        check("postflush_dispatch_ready", 32'(dispatch_ready), 1);
        for (int i = 0; i < DEPTH; i++) begin
            drive_dispatch(3, 0, 4, 0, 0, i, 0);
            next_step();
        end
        check("postflush_all_free_full", 32'(dispatch_ready), 0);
        check("postflush_pending_valid", 32'(issue_valid), 0);

        // Mid-operation reset beats flush, dispatch and wakeup
        rst       = 1'b1;
        flush     = 1'b1;
        cdb_valid = 2'b11;
        cdb_preg  = {6'd4, 6'd3};
        drive_dispatch(1, 1, 2, 1, 0, 9, 0);
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        #1;
        check("midrst_dispatch_ready", 32'(dispatch_ready), 1);
        check("midrst_issue_valid",    32'(issue_valid), 0);
        cdb_valid = 2'b11;
        cdb_preg  = {6'd4, 6'd3};
        next_step();
        check("midrst_no_stale_wake", 32'(issue_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, 8, entry count (power of 2, >=2).
REQ-002 SHALL have parameter PREG_W, 6, physical register tag width.
REQ-003 SHALL have parameter ROB_W, 5, ROB index width.
REQ-004 SHALL have parameter NUM_CDB, 2, number of broadcast (wakeup) ports.
REQ-005 SHALL have parameter CTRL_W, 32, opaque operation payload width.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port flush  input  1  discard all entries.
REQ-009 SHALL have port dispatch_valid  input  1  dispatch request.
REQ-010 SHALL have port dispatch_ready  output  1  free entry exists.
REQ-011 SHALL have port dispatch_ps1  input  PREG_W  source-1 tag.
REQ-012 SHALL have port dispatch_ps1_v  input  1  source-1 already available.
REQ-013 SHALL have port dispatch_ps2  input  PREG_W  source-2 tag.
REQ-014 SHALL have port dispatch_ps2_v  input  1  source-2 already available.
REQ-015 SHALL have port dispatch_pd  input  PREG_W  destination tag.
REQ-016 SHALL have port dispatch_rob  input  ROB_W  ROB entry index.
REQ-017 SHALL have port dispatch_ctrl  input  CTRL_W  operation payload.
REQ-018 SHALL have port cdb_valid  input  NUM_CDB  per-port broadcast valid.
REQ-019 SHALL have port cdb_preg  input  NUM_CDB*PREG_W  broadcast tags, port k at bits [k*PREG_W +: PREG_W].
REQ-020 SHALL have port issue_valid  output  1  an entry is issuable.
REQ-021 SHALL have port issue_ready  input  1  functional unit accepts.
REQ-022 SHALL have port issue_ps1 / issue_ps2  output  PREG_W each  selected entry source tags.
REQ-023 SHALL have port issue_pd  output  PREG_W  selected destination tag.
REQ-024 SHALL have port issue_rob  output  ROB_W  selected ROB index.
REQ-025 SHALL have port issue_ctrl  output  CTRL_W  selected payload.

Function
REQ-026 Dispatch SHALL occur when dispatch_valid && dispatch_ready; the lowest-index free entry is written (busy=1, all fields captured) at the edge.
REQ-027 dispatch_ready SHALL be 1 iff at least one entry is free in registered state, independent of same-cycle issue/flush; full (DEPTH busy) -> 0 and dispatch_valid ignored.
REQ-028 Wakeup SHALL set psX_v=1 at the edge for every busy entry with psX_v=0 where any cdb_valid[k] && cdb_preg[k]==psX; multiple matching ports are equivalent to one.
REQ-029 Dispatch bypass SHALL store psX_v=1 when a dispatched operand with psX_v=0 matches a same-cycle valid CDB tag.
REQ-030 Ready entry = busy && ps1_v && ps2_v (registered); issue_valid SHALL be combinational OR of ready entries, forced 0 while flush=1; CDB-to-issue_valid latency exactly 1 cycle.
REQ-031 issue_* payload SHALL reflect the selected entry and be all-zero when issue_valid=0; payload may change while stalled, consumer samples only on handshake.
REQ-032 issue_valid && issue_ready SHALL free the selected entry at the edge; a freed entry is reusable by dispatch from the next cycle only.
REQ-033 Simultaneous dispatch, issue and wakeup in one cycle SHALL all take effect independently.
REQ-034 flush SHALL clear all busy bits and age state at the edge; same-cycle dispatch and issue handshakes are discarded.

Reset
REQ-035 rst SHALL clear busy, operand-valid and age state at the edge, taking priority over flush, dispatch and wakeup; mid-operation reset drops all entries.
REQ-036 After reset: dispatch_ready=1, issue_valid=0, all issue_* =0.

Configuration
REQ-037 With RS_AGE_ORDER_EN defined, a DEPTHxDEPTH age matrix SHALL select the oldest-dispatched ready entry; undefined, the lowest-index ready entry SHALL be selected and no age storage built.

Verification
REQ-038 Dispatch ps1=5,v=0, ps2=6,v=1; next cycle cdb_valid=01, cdb_preg[0]=5 -> issue_valid=1 following cycle, issue_ps1=5, issue_ps2=6.
REQ-039 Dispatch ps1=9,v=0 with same-cycle cdb port1 tag 9 (ps2 v=1) -> issue_valid=1 next cycle.
REQ-040 issue_ready=0, 8 ready dispatches -> dispatch_ready=0 after 8th, 9th ignored; one issue handshake -> dispatch_ready=1 next cycle.
REQ-041 Entries 0 (rob 1), 1 (rob 2) dispatched; issue rob 1; dispatch rob 3 into entry 0; all ready -> with macro issue_rob=2 first, without issue_rob=3 first.
REQ-042 4 busy entries, flush=1 with dispatch_valid=1 -> issue_valid=0 that cycle; next cycle issue_valid=0, dispatch_ready=1, no entries retained.
